branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Consumer side of the branch comparator interface in the EX stage.
- Drives the comparator's unsigned-select input and consumes its less/equal flags.
- Decides the actual branch/jump outcome and compares it with the fetch-stage prediction.
- On a mispredict, issues a registered redirect to fetch with a valid/ready handshake, then holds a flush window on the front-end pipeline.

Parameters:
FLUSH_CYCLES, 2, cycles o_flush stays high after redirect accept (0 allowed = no flush window)
CNT_W, 32, width of the performance counters (only meaningful with BRANCH_PERF_EN)

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  synchronous reset, active-high
i_valid  input  1  control-transfer instruction present in EX this cycle
i_isBranch  input  1  conditional branch (uses i_funct3)
i_isJump  input  1  JAL/JALR, always taken
i_funct3  input  3  branch funct3
i_brLess  input  1  less flag from comparator
i_brEqual  input  1  equal flag from comparator
i_pc  input  32  PC of the instruction
i_target  input  32  computed taken target
i_predTaken  input  1  fetch prediction for this instruction
i_redirectReady  input  1  fetch accepts redirect
o_brUnsign  output  1  unsigned-compare select to comparator
o_redirectValid  output  1  redirect request to fetch
o_redirectPc  output  32  corrected PC
o_flush  output  1  kill younger front-end instructions
o_stall  output  1  hold EX and earlier stages
o_illegal  output  1  one-cycle pulse: reserved funct3 on a branch
o_misalign  output  1  one-cycle pulse: taken target with [1:0] != 0
o_brCount  output  CNT_W  resolved branch/jump count
o_mispCount  output  CNT_W  mispredict count

Behaviour:
- o_brUnsign = i_funct3[1], combinational, independent of state.
- Taken decision (combinational) when i_isBranch:
  - 000 BEQ = eq; 001 BNE = !eq.
  - 100 BLT and 110 BLTU = less; 101 BGE and 111 BGEU = !less.
  - 010/011 = not taken, and o_illegal pulses.
- i_isJump = taken. i_isBranch and i_isJump both high: jump wins.
- Actual next PC: taken → i_target; not taken → i_pc + 32'd4, wrapping modulo 2^32.
- Mispredict = taken != i_predTaken.
- FSM states are IDLE, REDIRECT and FLUSH. Inputs are sampled only in IDLE; in other states i_valid is ignored. Upstream holds via o_stall.
- IDLE, i_valid=1:
  - Taken and misaligned target: pulse o_misalign, no redirect, stay IDLE.
  - Illegal funct3: pulse o_illegal. Treated as not-taken and can still mispredict.
  - Mispredict: next cycle o_redirectValid=1, o_redirectPc = actual next PC, state REDIRECT. Latency is 1 cycle.
  - Otherwise: stay IDLE.
- REDIRECT:
  - o_redirectValid and o_redirectPc hold stable until i_redirectReady=1. The transfer happens on that cycle.
  - Next state after transfer: FLUSH with counter = FLUSH_CYCLES. If FLUSH_CYCLES=0, next state is IDLE.
  - o_redirectValid drops the cycle after transfer.
- FLUSH: o_flush=1, counter decrements each cycle, and the state returns to IDLE after exactly FLUSH_CYCLES cycles.
- o_stall = (state != IDLE).
- o_illegal and o_misalign are registered one-cycle pulses, driven the cycle after sampling.
- Reset, including reset asserted mid-operation:
  - State → IDLE; o_redirectValid, o_redirectPc, o_flush, o_illegal, o_misalign and the counters → 0.
  - A pending redirect is dropped. Reset has priority over every other event.

Optional Feature:
BRANCH_PERF_EN
- Defined:
  - o_brCount increments on each IDLE sample with i_valid=1.
  - o_mispCount increments on each IDLE sample where a redirect is issued.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- BLT, funct3=100, brLess=1, predTaken=0, pc=0x100, target=0x80 → o_brUnsign=0; next cycle o_redirectValid=1, o_redirectPc=0x80, o_stall=1.
- BGEU, funct3=111, brLess=0, predTaken=1, pc=0xFFFFFFFC → o_brUnsign=1; taken, so no redirect. Then same with brLess=1 → redirect to 0x00000000 (wrap).
- Redirect with i_redirectReady low for 3 cycles → o_redirectValid/o_redirectPc stable; on accept, o_flush high exactly 2 cycles, then o_stall=0. Repeat with FLUSH_CYCLES=0 → no o_flush, IDLE next cycle.
- JAL, target=0x102 → o_misalign pulses one cycle, no redirect. funct3=010 branch, predTaken=1 → o_illegal pulse plus redirect to pc+4.
- i_reset asserted while in REDIRECT, then again during FLUSH → next cycle all outputs 0, IDLE, and a new branch is accepted normally.
- BRANCH_PERF_EN: 5 branches with 2 mispredicts → o_brCount=5, o_mispCount=2. Without the macro → both 0.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Redirect channel from the EX-stage branch resolver to fetch (valid/ready).
interface branch_resolve_unit_if;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        redirectReady;

  modport master (output redirectValid, output redirectPc, input  redirectReady);
  modport slave  (input  redirectValid, input  redirectPc, output redirectReady);
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: outcome vs prediction, registered redirect, flush window.
// Optional perf counters enabled by defining BRANCH_PERF_EN.
module branch_resolve_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_isBranch,
  input  logic                  i_isJump,
  input  logic [2:0]            i_funct3,
  input  logic                  i_brLess,
  input  logic                  i_brEqual,
  input  logic [31:0]           i_pc,
  input  logic [31:0]           i_target,
  input  logic                  i_predTaken,
  branch_resolve_unit_if.master redir,
  output logic                  o_brUnsign,
  output logic                  o_flush,
  output logic                  o_stall,
  output logic                  o_illegal,
  output logic                  o_misalign,
  output logic [CNT_W-1:0]      o_brCount,
  output logic [CNT_W-1:0]      o_mispCount
);

  localparam int FC_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t            r_state, w_stateNxt;
  logic [FC_W-1:0]   r_cnt, w_cntNxt;
  logic              r_redirectValid, w_redirectValidNxt;
  logic [31:0]       r_redirectPc, w_redirectPcNxt;
  logic              r_illegal, w_illegalNxt;
  logic              r_misalign, w_misalignNxt;

  logic              w_brTaken, w_badF3, w_taken, w_illegal, w_misalignTgt, w_misp, w_sample;
  logic [31:0]       w_nextPc;

  assign o_brUnsign = i_funct3[1];

  always_comb begin
    w_brTaken = 1'b0;
    w_badF3   = 1'b0;
    case (i_funct3)
      3'b000:         w_brTaken = i_brEqual;
      3'b001:         w_brTaken = ~i_brEqual;
      3'b100, 3'b110: w_brTaken = i_brLess;
      3'b101, 3'b111: w_brTaken = ~i_brLess;
      default:        w_badF3   = 1'b1;
    endcase
  end

  // Jumps override any branch decode, so funct3 is irrelevant for them.
  assign w_taken       = i_isJump | (i_isBranch & w_brTaken);
  assign w_illegal     = i_isBranch & ~i_isJump & w_badF3;
  assign w_misalignTgt = w_taken & (i_target[1:0] != 2'b00);
  assign w_nextPc      = w_taken ? i_target : i_pc + 32'd4;
  assign w_misp        = w_taken != i_predTaken;
  assign w_sample      = (r_state == IDLE) & i_valid;

  always_comb begin
    w_stateNxt         = r_state;
    w_cntNxt           = r_cnt;
    w_redirectValidNxt = r_redirectValid;
    w_redirectPcNxt    = r_redirectPc;
    w_illegalNxt       = 1'b0;
    w_misalignNxt      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sample) begin
          if (w_misalignTgt) begin
            w_misalignNxt = 1'b1;
          end else begin
            w_illegalNxt = w_illegal;
            if (w_misp) begin
              w_redirectValidNxt = 1'b1;
              w_redirectPcNxt    = w_nextPc;
              w_stateNxt         = REDIRECT;
            end
          end
        end
      end
      REDIRECT: begin
        if (redir.redirectReady) begin
          w_redirectValidNxt = 1'b0;
          if (FLUSH_CYCLES == 0) begin
            w_stateNxt = IDLE;
          end else begin
            w_stateNxt = FLUSH;
            w_cntNxt   = FC_LOAD;
          end
        end
      end
      FLUSH: begin
        w_cntNxt = r_cnt - FC_W'(1);
        if (r_cnt <= FC_W'(1)) w_stateNxt = IDLE;
      end
      default: w_stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_redirectValid <= 1'b0;
      r_redirectPc    <= '0;
      r_illegal       <= 1'b0;
      r_misalign      <= 1'b0;
    end else begin
      r_state         <= w_stateNxt;
      r_cnt           <= w_cntNxt;
      r_redirectValid <= w_redirectValidNxt;
      r_redirectPc    <= w_redirectPcNxt;
      r_illegal       <= w_illegalNxt;
      r_misalign      <= w_misalignNxt;
    end
  end

  assign redir.redirectValid = r_redirectValid;
  assign redir.redirectPc    = r_redirectPc;
  assign o_flush             = (r_state == FLUSH);
  assign o_stall             = (r_state != IDLE);
  assign o_illegal           = r_illegal;
  assign o_misalign          = r_misalign;

`ifdef BRANCH_PERF_EN
  logic             w_issue;
  logic [CNT_W-1:0] r_brCount, r_mispCount;

  assign w_issue = w_sample & ~w_misalignTgt & w_misp;

  // Saturating so long runs never wrap back to small values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_brCount   <= '0;
      r_mispCount <= '0;
    end else begin
      if (w_sample && (r_brCount != '1))  r_brCount   <= r_brCount + CNT_W'(1);
      if (w_issue && (r_mispCount != '1)) r_mispCount <= r_mispCount + CNT_W'(1);
    end
  end

  assign o_brCount   = r_brCount;
  assign o_mispCount = r_mispCount;
`else
  assign o_brCount   = '0;
  assign o_mispCount = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: u0 uses FLUSH_CYCLES=2, u1 uses FLUSH_CYCLES=0.
module tb_branch_resolve_unit;
  logic        i_clk = 1'b0;
  logic        i_reset, i_valid, i_isBranch, i_isJump, i_brLess, i_brEqual, i_predTaken, rdy;
  logic [2:0]  i_funct3;
  logic [31:0] i_pc, i_target;

  logic        a_unsign, a_flush, a_stall, a_ill, a_mis;
  logic [31:0] a_brc, a_mpc;
  logic        b_unsign, b_flush, b_stall, b_ill, b_mis;
  logic [31:0] b_brc, b_mpc;

  int checks = 0;
  int failures = 0;
  logic [4:0] st;

  always #5 i_clk = ~i_clk;

  branch_resolve_unit_if ifA();
  branch_resolve_unit_if ifB();
  assign ifA.redirectReady = rdy;
  assign ifB.redirectReady = rdy;

  branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(32)) u0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_isBranch(i_isBranch),
    .i_isJump(i_isJump), .i_funct3(i_funct3), .i_brLess(i_brLess), .i_brEqual(i_brEqual),
    .i_pc(i_pc), .i_target(i_target), .i_predTaken(i_predTaken), .redir(ifA),
    .o_brUnsign(a_unsign), .o_flush(a_flush), .o_stall(a_stall), .o_illegal(a_ill),
    .o_misalign(a_mis), .o_brCount(a_brc), .o_mispCount(a_mpc));

  branch_resolve_unit #(.FLUSH_CYCLES(0), .CNT_W(32)) u1 (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_isBranch(i_isBranch),
    .i_isJump(i_isJump), .i_funct3(i_funct3), .i_brLess(i_brLess), .i_brEqual(i_brEqual),
    .i_pc(i_pc), .i_target(i_target), .i_predTaken(i_predTaken), .redir(ifB),
    .o_brUnsign(b_unsign), .o_flush(b_flush), .o_stall(b_stall), .o_illegal(b_ill),
    .o_misalign(b_mis), .o_brCount(b_brc), .o_mispCount(b_mpc));

  // Packed status of u0: {redirectValid, flush, stall, illegal, misalign}
  assign st = {ifA.redirectValid, a_flush, a_stall, a_ill, a_mis};

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic br, input logic jmp, input logic [2:0] f3, input logic less,
                       input logic eq, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pred);
    i_valid = 1'b1; i_isBranch = br; i_isJump = jmp; i_funct3 = f3;
    i_brLess = less; i_brEqual = eq; i_pc = pc; i_target = tgt; i_predTaken = pred;
  endtask

  task automatic send(input logic br, input logic jmp, input logic [2:0] f3, input logic less,
                      input logic eq, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic pred);
    issue(br, jmp, f3, less, eq, pc, tgt, pred);
    cyc();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    rdy = 1'b1; cyc(); rdy = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_valid = 1'b0; rdy = 1'b0;
    issue(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    i_valid = 1'b0;
    cyc(); cyc();
    i_reset = 1'b0;
    checks++;
    if (st !== 5'b00000) begin failures++; $display("FAIL reset_status got %b exp 00000", st); end
    checks++;
    if (ifA.redirectPc !== 32'h0) begin failures++; $display("FAIL reset_pc got %h exp 0", ifA.redirectPc); end
    checks++;
    if ({a_brc, a_mpc} !== 64'h0) begin failures++; $display("FAIL reset_cnt got %h/%h exp 0/0", a_brc, a_mpc); end
  endtask

  task automatic test_blt_hold();
    issue(1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 32'h100, 32'h80, 1'b0);
    #1;
    checks++;
    if (a_unsign !== 1'b0) begin failures++; $display("FAIL blt_unsign got %b exp 0", a_unsign); end
    cyc(); i_valid = 1'b0;
    checks++;
    if (st !== 5'b10100 || ifA.redirectPc !== 32'h80) begin
      failures++; $display("FAIL blt_redirect got %b pc %h exp 10100 pc 00000080", st, ifA.redirectPc);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (st !== 5'b10100 || ifA.redirectPc !== 32'h80) begin
        failures++; $display("FAIL hold_%0d got %b pc %h exp 10100 pc 00000080", k, st, ifA.redirectPc);
      end
    end
    rdy = 1'b1; cyc(); rdy = 1'b0;
    checks++;
    if (st !== 5'b01100) begin failures++; $display("FAIL flush_1 got %b exp 01100", st); end
    checks++;
    if ({ifB.redirectValid, b_flush, b_stall} !== 3'b000) begin
      failures++; $display("FAIL noflush_u1 got %b exp 000", {ifB.redirectValid, b_flush, b_stall});
    end
    cyc();
    checks++;
    if (st !== 5'b01100) begin failures++; $display("FAIL flush_2 got %b exp 01100", st); end
    cyc();
    checks++;
    if (st !== 5'b00000) begin failures++; $display("FAIL flush_end got %b exp 00000", st); end
  endtask

  task automatic test_bgeu_wrap();
    issue(1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h40, 1'b1);
    #1;
    checks++;
    if (a_unsign !== 1'b1) begin failures++; $display("FAIL bgeu_unsign got %b exp 1", a_unsign); end
    cyc(); i_valid = 1'b0;
    checks++;
    if (st !== 5'b00000) begin failures++; $display("FAIL bgeu_correct got %b exp 00000", st); end
    send(1'b1, 1'b0, 3'b111, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h40, 1'b1);
    checks++;
    if (st !== 5'b10100 || ifA.redirectPc !== 32'h0) begin
      failures++; $display("FAIL bgeu_wrap got %b pc %h exp 10100 pc 00000000", st, ifA.redirectPc);
    end
    drain();
    checks++;
    if (st !== 5'b00000) begin failures++; $display("FAIL bgeu_drain got %b exp 00000", st); end
  endtask

  task automatic test_misalign();
    send(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h100, 32'h102, 1'b0);
    checks++;
    if (st !== 5'b00001) begin failures++; $display("FAIL misalign_pulse got %b exp 00001", st); end
    cyc();
    checks++;
    if (st !== 5'b00000) begin failures++; $display("FAIL misalign_drop got %b exp 00000", st); end
  endtask

  task automatic test_illegal();
    send(1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 32'h200, 32'h500, 1'b1);
    checks++;
    if (st !== 5'b10110 || ifA.redirectPc !== 32'h204) begin
      failures++; $display("FAIL illegal_redirect got %b pc %h exp 10110 pc 00000204", st, ifA.redirectPc);
    end
    cyc();
    checks++;
    if (st !== 5'b10100) begin failures++; $display("FAIL illegal_drop got %b exp 10100", st); end
    drain();
  endtask

  task automatic test_reset_mid();
    send(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 32'h10, 32'h400, 1'b0);
    rdy = 1'b1; i_reset = 1'b1; cyc(); i_reset = 1'b0; rdy = 1'b0;
    checks++;
    if (st !== 5'b00000 || ifA.redirectPc !== 32'h0) begin
      failures++; $display("FAIL rst_redirect got %b pc %h exp 00000 pc 0", st, ifA.redirectPc);
    end
    cyc();
    checks++;
    if (st !== 5'b00000 || ifB.redirectValid !== 1'b0) begin
      failures++; $display("FAIL rst_dropped got %b u1v %b exp 00000 0", st, ifB.redirectValid);
    end
    send(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 32'h10, 32'h400, 1'b0);
    rdy = 1'b1; cyc(); rdy = 1'b0;
    checks++;
    if (st !== 5'b01100) begin failures++; $display("FAIL rst_pre_flush got %b exp 01100", st); end
    i_reset = 1'b1; cyc(); i_reset = 1'b0;
    checks++;
    if (st !== 5'b00000 || ifA.redirectPc !== 32'h0) begin
      failures++; $display("FAIL rst_flush got %b pc %h exp 00000 pc 0", st, ifA.redirectPc);
    end
    send(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'h10, 32'h300, 1'b0);
    checks++;
    if (st !== 5'b10100 || ifA.redirectPc !== 32'h300) begin
      failures++; $display("FAIL rst_recover got %b pc %h exp 10100 pc 00000300", st, ifA.redirectPc);
    end
    drain();
  endtask

  task automatic test_perf();
    logic [31:0] exp_br, exp_mp;
`ifdef BRANCH_PERF_EN
    exp_br = 32'd5; exp_mp = 32'd2;
`else
    exp_br = 32'd0; exp_mp = 32'd0;
`endif
    i_reset = 1'b1; cyc(); i_reset = 1'b0;
    send(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'h20, 32'h60, 1'b1);
    send(1'b1, 1'b0, 3'b001, 1'b0, 1'b1, 32'h24, 32'h60, 1'b0);
    send(1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 32'h28, 32'h60, 1'b0);
    drain();
    send(1'b1, 1'b0, 3'b101, 1'b1, 1'b0, 32'h2C, 32'h60, 1'b0);
    send(1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 32'h30, 32'h60, 1'b1);
    drain();
    checks++;
    if (a_brc !== exp_br) begin failures++; $display("FAIL perf_br got %0d exp %0d", a_brc, exp_br); end
    checks++;
    if (a_mpc !== exp_mp) begin failures++; $display("FAIL perf_misp got %0d exp %0d", a_mpc, exp_mp); end
  endtask

  initial begin
    test_reset();
    test_blt_hold();
    test_bgeu_wrap();
    test_misalign();
    test_illegal();
    test_reset_mid();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
